// File: rtl/reg_file_mp_pkg.sv
// Shared types and helpers for the multi-port byte-writable register file.
// Provides the clear-sequencer state type and the byte-lane merge function.
package reg_file_mp_pkg;

    typedef enum logic {CLEAR, IDLE} clr_state_e;

    // Widest word the merge helper handles; callers cast in and out.
    localparam int MAX_DW    = 1024;
    localparam int MAX_BYTES = MAX_DW / 8;

    // Enabled byte lanes take new_d, the rest keep old_d.
    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0]    old_d,
        input logic [MAX_DW-1:0]    new_d,
        input logic [MAX_BYTES-1:0] be
    );
        logic [MAX_DW-1:0] mask;
        for (int i = 0; i < MAX_BYTES; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return (new_d & mask) | (old_d & ~mask);
    endfunction

endpackage

// File: rtl/reg_file_mp_clr_seq.sv
// Clear sequencer: walks every word address once after reset or clr_req.
// Ports: clk, rst (sync, active high), clr_req in; busy, clr_we, clr_addr out.
module reg_file_mp_clr_seq
    import reg_file_mp_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    clr_state_e            state;
    logic [ADDR_WIDTH-1:0] clr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
        end else begin
            unique case (state)
                CLEAR: begin
                    // Pointer parks on the last word instead of wrapping.
                    if (&clr_ptr) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                        busy    <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign clr_we   = (state == CLEAR);
    assign clr_addr = clr_ptr;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port byte-writable register file with hardware clear and read strobes.
// Ports: clk, rst, rd_en/rd_addr -> rd_data/rd_valid (1-cycle latency),
//        wr_en/wr_addr/byte_en/wr_data, clr_req, busy.
// Define REG_FILE_MP_BYPASS_EN to forward same-cycle write data to reads.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter  int BYTE_ADDR_WIDTH    = 6,
    parameter  int DATA_WIDTH         = 32,
    parameter  int NUM_RD_PORTS       = 2,
    localparam int NUM_BYTES_PER_WORD = DATA_WIDTH / 8,
    localparam int WORD_ADDR_WIDTH    =
        BYTE_ADDR_WIDTH - $clog2(NUM_BYTES_PER_WORD),
    localparam int NUM_WORDS          = 2 ** WORD_ADDR_WIDTH
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NUM_RD_PORTS-1:0]                      rd_en,
    input  logic [NUM_RD_PORTS-1:0][WORD_ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0]      rd_data,
    output logic [NUM_RD_PORTS-1:0]                      rd_valid,
    input  logic                                         wr_en,
    input  logic [WORD_ADDR_WIDTH-1:0]                   wr_addr,
    input  logic [NUM_BYTES_PER_WORD-1:0]                byte_en,
    input  logic [DATA_WIDTH-1:0]                        wr_data,
    input  logic                                         clr_req,
    output logic                                         busy
);

    logic [DATA_WIDTH-1:0]      mem [NUM_WORDS];
    logic [DATA_WIDTH-1:0]      wr_merged;
    logic [DATA_WIDTH-1:0]      rd_word [NUM_RD_PORTS];
    logic                       clr_we;
    logic [WORD_ADDR_WIDTH-1:0] clr_addr;

    reg_file_mp_clr_seq #(
        .ADDR_WIDTH(WORD_ADDR_WIDTH)
    ) u_clr_seq (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    always_comb begin
        wr_merged = DATA_WIDTH'(byte_merge(
            MAX_DW'(mem[wr_addr]),
            MAX_DW'(wr_data),
            MAX_BYTES'(byte_en)));
    end

    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_word[p] = mem[rd_addr[p]];
`ifdef REG_FILE_MP_BYPASS_EN
            // Same word being written: wr_merged already holds the
            // stored bytes overlaid with the enabled write lanes.
            if (wr_en && (rd_addr[p] == wr_addr)) begin
                rd_word[p] = wr_merged;
            end
`endif
        end
    end

    // Storage has no reset; the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem[clr_addr] <= '0;
            end else if (wr_en) begin
                mem[wr_addr] <= wr_merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else if (busy) begin
            rd_valid <= '0;
        end else begin
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                rd_valid[p] <= rd_en[p];
                if (rd_en[p]) begin
                    rd_data[p] <= rd_word[p];
                end
            end
        end
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port, byte-writable register file; next generation of the team's 2-read/1-write word register file.
- Generalised in data width and read-port count.
- Adds a hardware clear sequencer (reset and software-requested), per-port read-valid strobes and a busy flag.
- Sits between the core's decode/execute stages and the architectural register state; one registered read stage per port.

Parameters:
BYTE_ADDR_WIDTH, 6, byte address width; storage = 2**BYTE_ADDR_WIDTH bytes.
DATA_WIDTH, 32, word width in bits; must be a multiple of 8 and at least 8.
NUM_RD_PORTS, 2, number of independent read channels; at least 1.
Derived (localparam): NUM_BYTES_PER_WORD = DATA_WIDTH/8; WORD_ADDR_WIDTH = BYTE_ADDR_WIDTH - $clog2(NUM_BYTES_PER_WORD); NUM_WORDS = 2**WORD_ADDR_WIDTH.

Ports:
clk  input  1  single clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
rd_en  input  NUM_RD_PORTS  per-port read request.
rd_addr  input  NUM_RD_PORTS x WORD_ADDR_WIDTH  per-port word address (packed array, port 0 in LSBs).
rd_data  output  NUM_RD_PORTS x DATA_WIDTH  registered per-port read data.
rd_valid  output  NUM_RD_PORTS  one-cycle strobe; rd_data of that port updated this cycle.
wr_en  input  1  write request.
wr_addr  input  WORD_ADDR_WIDTH  write word address.
byte_en  input  NUM_BYTES_PER_WORD  per-byte write enable; bit i covers wr_data[8i+7:8i].
wr_data  input  DATA_WIDTH  write data.
clr_req  input  1  single-cycle request to zero the whole array.
busy  output  1  high while clear sequence runs; reads and writes ignored.

Behaviour:
- States: CLEAR, IDLE.
  - rst=1 forces CLEAR with clr_ptr=0; this holds for the whole time rst is high, so reset mid-clear restarts from word 0.
- Reset values: rd_data=0 for all ports, rd_valid=0, busy=1, clr_ptr=0.
- CLEAR, each cycle with rst=0:
  - word[clr_ptr] <= 0 (all bytes); clr_ptr++.
  - When clr_ptr==NUM_WORDS-1 the word is written and the next state is IDLE.
  - Takes exactly NUM_WORDS cycles after rst deasserts; busy drops in the first IDLE cycle.
- CLEAR, inputs ignored:
  - rd_en, wr_en and clr_req are ignored; no storage write other than the clear.
  - rd_valid stays 0 and rd_data holds its value.
- IDLE, clr_req=1: next state is CLEAR with clr_ptr=0. A write in the same cycle is still performed; the clear later overwrites it.
- Write (IDLE, wr_en=1): byte i of word[wr_addr] <= wr_data byte i when byte_en[i]=1; other bytes unchanged. byte_en=0 means no change.
- Read (IDLE, rd_en[p]=1):
  - rd_data[p] <= word[rd_addr[p]] and rd_valid[p] <= 1 on the next edge; latency 1.
  - rd_en[p]=0 gives rd_valid[p]=0 with rd_data[p] held.
- Multiple ports may read the same address in one cycle; each returns identical data.
- Read/write same address, same cycle, without bypass: read returns pre-write contents (read-before-write).
- Address ranges are full power-of-two, so there is no out-of-range case; clr_ptr does not wrap past NUM_WORDS-1.

Optional Feature:
Macro REG_FILE_MP_BYPASS_EN.
- Defined: when wr_en=1 and rd_addr[p]==wr_addr in IDLE, rd_data[p] takes per-byte merged data. Enabled bytes come from wr_data; disabled bytes come from stored contents. This is write-to-read forwarding.
- Undefined: read-before-write as above, with no forwarding muxes.

Decomposition:
- Package reg_file_mp_pkg:
  - typedef enum logic {CLEAR, IDLE} clr_state_e;
  - function to compute the byte-lane merge of old and new data under byte_en (shared by the write path and the bypass path).
- Sub-module reg_file_mp_clr_seq: state register, clr_ptr counter, busy, and the clear-write strobe/address. The storage array and read ports stay in the top.

Test Plan:
- Reset then clear timing: assert rst 3 cycles, release -> busy=1 for exactly 16 cycles (defaults), then 0; all 16 words read back 0x00000000 on ports 0 and 1.
- Byte-enable writes: write 0xDEADBEEF to word 5 with byte_en=4'b1111, then 0x11223344 with byte_en=4'b0101 -> read of word 5 returns 0xDE22BE44 one cycle after rd_en, with rd_valid pulsing for one cycle.
- Multi-port read: ports 0 and 1 read word 5 and word 0 in the same cycle -> 0xDE22BE44 and 0x00000000; next cycle rd_en=0 -> rd_valid=0 and rd_data held.
- Same-cycle read/write on word 7 (holding 0xAAAAAAAA), writing 0x55555555 with byte_en=4'b0011:
  - without REG_FILE_MP_BYPASS_EN -> 0xAAAAAAAA.
  - with REG_FILE_MP_BYPASS_EN -> 0xAAAA5555.
  - either way, a follow-up read returns 0xAAAA5555.
- Software clear: write 0x12345678 to word 3, pulse clr_req with a simultaneous write to word 9 -> busy high 16 cycles; writes and rd_en during busy are ignored (rd_valid=0); afterwards words 3 and 9 read 0.
- Reset mid-clear: pulse clr_req, assert rst at clear cycle 8 for 1 cycle -> busy stays high and the sequence restarts, finishing 16 cycles after rst release.
